// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encodings and small op-decoding helpers.
package muldiv_unit_pkg;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULS) || (op == OP_DIVS);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIVS);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: one shift-add or restoring-divide step per cycle
// on operand magnitudes, sign correction in a final FIX cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WID = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [DATA_WID-1:0] srcdata_a,
    input  logic [DATA_WID-1:0] srcdata_b,
    output logic                busy,
    output logic                done,
    output logic [DATA_WID-1:0] result_hi,
    output logic [DATA_WID-1:0] result_lo,
    output logic                div_zero
);

    localparam int CNT_W = $clog2(DATA_WID) + 1;

    function automatic logic [DATA_WID-1:0] neg_w(input logic [DATA_WID-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*DATA_WID-1:0] neg_2w(input logic [2*DATA_WID-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_count;
    logic                  r_done;
    logic [DATA_WID-1:0]   r_res_hi;
    logic [DATA_WID-1:0]   r_res_lo;
    logic                  r_div_zero;

    logic [2*DATA_WID-1:0] r_acc;
    logic [DATA_WID-1:0]   r_operand;
    logic                  r_is_div;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic                  r_zero;

    logic                  w_accept;
    logic                  w_sign_a;
    logic                  w_sign_b;
    logic [DATA_WID-1:0]   w_mag_a;
    logic [DATA_WID-1:0]   w_mag_b;
    logic [DATA_WID:0]     w_mul_sum;
    logic [2*DATA_WID-1:0] w_mul_next;
    logic [DATA_WID:0]     w_rem_ext;
    logic [DATA_WID-1:0]   w_diff;
    logic                  w_ge;
    logic [2*DATA_WID-1:0] w_div_next;
    logic                  w_neg;
    logic [2*DATA_WID-1:0] w_prod;
    logic [DATA_WID-1:0]   w_fix_hi;
    logic [DATA_WID-1:0]   w_fix_lo;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_sign_a = op_is_signed(op) & srcdata_a[DATA_WID-1];
    assign w_sign_b = op_is_signed(op) & srcdata_b[DATA_WID-1];
    assign w_mag_a  = neg_w(srcdata_a, w_sign_a);
    assign w_mag_b  = neg_w(srcdata_b, w_sign_b);

    // Shift-add step: conditionally add multiplier into the upper half, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_WID-1:DATA_WID]}
                      + (r_acc[0] ? {1'b0, r_operand} : {(DATA_WID+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[DATA_WID-1:1]};

    // Restoring step; a zero divisor always "fits", yielding all-ones quotient and remainder == dividend.
    assign w_rem_ext  = r_acc[2*DATA_WID-1:DATA_WID-1];
    assign w_ge       = (w_rem_ext >= {1'b0, r_operand});
    assign w_diff     = w_rem_ext[DATA_WID-1:0] - r_operand;
    assign w_div_next = w_ge ? {w_diff, r_acc[DATA_WID-2:0], 1'b1}
                             : {w_rem_ext[DATA_WID-1:0], r_acc[DATA_WID-2:0], 1'b0};

    assign w_neg  = r_sign_a ^ r_sign_b;
    assign w_prod = neg_2w(r_acc, w_neg);

    always_comb begin
        w_fix_hi = w_prod[2*DATA_WID-1:DATA_WID];
        w_fix_lo = w_prod[DATA_WID-1:0];
        if (r_is_div) begin
            w_fix_hi = neg_w(r_acc[2*DATA_WID-1:DATA_WID], r_sign_a);
            w_fix_lo = r_zero ? {DATA_WID{1'b1}} : neg_w(r_acc[DATA_WID-1:0], w_neg);
        end
    end

    // Control and visible results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CALC;
                        r_count <= '0;
                    end
                end
                ST_CALC: begin
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(DATA_WID - 1))
                        r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_res_hi   <= w_fix_hi;
                    r_res_lo   <= w_fix_lo;
                    r_div_zero <= r_zero;
                    r_done     <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc     <= {{DATA_WID{1'b0}}, w_mag_a};
            r_operand <= w_mag_b;
            r_is_div  <= op_is_div(op);
            r_sign_a  <= w_sign_a;
            r_sign_b  <= w_sign_b;
            r_zero    <= op_is_div(op) && (srcdata_b == '0);
        end else if (r_state == ST_CALC) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign result_hi = r_res_hi;
    assign result_lo = r_res_lo;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences
// and random ops compared against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result_hi;
    logic [15:0] result_lo;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.DATA_WID(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .srcdata_a (a),
        .srcdata_b (b),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural operand values.
    function automatic logic [32:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [63:0] p;
        int          sx, sy, q, r;
        logic [31:0] qv, rv;
        case (o)
            OP_MULU: begin
                p = longint'(x) * longint'(y);
                return {1'b0, p[31:0]};
            end
            OP_MULS: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return {1'b0, p[31:0]};
            end
            default: begin
                if (y == 16'h0) return {1'b1, x, 16'hFFFF};
                if (o == OP_DIVU) begin
                    sx = int'(x);
                    sy = int'(y);
                end else begin
                    sx = int'($signed(x));
                    sy = int'($signed(y));
                end
                q  = sx / sy;
                r  = sx % sy;
                qv = q;
                rv = r;
                return {1'b0, rv[15:0], qv[15:0]};
            end
        endcase
    endfunction

    // Entered at a negedge; leaves at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          input bit inject,
                          output logic [15:0] hi, output logic [15:0] lo, output logic dz);
        logic [15:0] ph, pl;
        bit          got;
        int          busy_n;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
        ph = result_hi; pl = result_lo;
        got = 0; busy_n = 0;
        hi = 'x; lo = 'x; dz = 1'bx;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (inject && n == 5) begin
                start = 1'b1; op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
            end else if (inject && n == 6) begin
                start = 1'b0;
            end
            if (done) begin
                got = 1;
                check("latency", 32'(n), 32'd18);
                check("busy at done", {31'b0, busy}, 32'd0);
                hi = result_hi; lo = result_lo; dz = div_zero;
            end else begin
                if (busy) busy_n++;
                if (n == 10) check("hold while busy", {result_hi, result_lo}, {ph, pl});
            end
        end
        start = 1'b0;
        if (!got) check("done timeout", 32'd0, 32'd1);
        check("busy cycles", 32'(busy_n), 32'd17);
    endtask

    vec_t        vecs[12];
    logic [15:0] hi, lo;
    logic        dz;
    logic [32:0] exp;
    int          done_cnt;

    initial begin
        vecs[0]  = '{OP_MULU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
        vecs[1]  = '{OP_MULS, 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0};
        vecs[2]  = '{OP_MULS, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
        vecs[3]  = '{OP_DIVU, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0};
        vecs[4]  = '{OP_DIVS, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
        vecs[5]  = '{OP_DIVS, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
        vecs[6]  = '{OP_DIVU, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
        vecs[7]  = '{OP_DIVU, 16'd9,    16'd3,    16'd0,    16'd3,    1'b0};
        vecs[8]  = '{OP_DIVS, 16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 1'b1};
        vecs[9]  = '{OP_DIVS, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
        vecs[10] = '{OP_MULS, 16'h0007, 16'hFFFF, 16'hFFFF, 16'hFFF9, 1'b0};
        vecs[11] = '{OP_MULU, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0};

        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", {result_hi, result_lo}, 32'd0);
        check("reset div_zero", {31'b0, div_zero}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, hi, lo, dz);
            check($sformatf("vec%0d hi", i), {16'b0, hi}, {16'b0, vecs[i].hi});
            check($sformatf("vec%0d lo", i), {16'b0, lo}, {16'b0, vecs[i].lo});
            check($sformatf("vec%0d div_zero", i), {31'b0, dz}, {31'b0, vecs[i].dz});
            @(negedge clk);
            check("done one cycle", {31'b0, done}, 32'd0);
        end

        // start while busy must be ignored
        run_op(OP_MULU, 16'h0102, 16'h0304, 1'b1, hi, lo, dz);
        check("ignored start result", {hi, lo}, 32'h0003_0A08);
        @(negedge clk);

        // back-to-back: second start issued in the done cycle
        run_op(OP_DIVU, 16'd100, 16'd7, 1'b0, hi, lo, dz);
        check("b2b first", {hi, lo}, {16'd2, 16'd14});
        run_op(OP_MULS, 16'hFFFD, 16'h0007, 1'b0, hi, lo, dz);
        check("b2b second", {hi, lo}, 32'hFFFF_FFEB);
        @(negedge clk);

        // reset in the middle of an operation
        start = 1'b1; op = OP_MULU; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset result", {result_hi, result_lo}, 32'd0);
        check("midreset div_zero", {31'b0, div_zero}, 32'd0);
        done_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no done after reset", 32'(done_cnt), 32'd0);

        run_op(OP_DIVS, 16'hFFF9, 16'h0002, 1'b0, hi, lo, dz);
        check("post-reset op", {hi, lo}, 32'hFFFF_FFFD);
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            logic [1:0]  ro;
            logic [15:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            exp = model(ro, ra, rb);
            run_op(ro, ra, rb, 1'b0, hi, lo, dz);
            check($sformatf("rand%0d op%0d %h,%h", i, ro, ra, rb), {hi, lo}, exp[31:0]);
            check($sformatf("rand%0d div_zero", i), {31'b0, dz}, {31'b0, exp[32]});
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
